// File: rtl/receiver_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame geometry and
// the parity helper that the transmitter also uses.
package receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_WIDTH = 8;

  // Parity bit a transmitter appends to 'word' (zero-extended data).
  function automatic logic parity_of(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/receiver_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receive stage: oversampled start/data/parity/stop framing into a
// parallel word with one-cycle valid, framing-error and parity-error strobes.
module receiver
  import receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  rx_clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic                  rx_s;
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  pe_q, pe_d;

  rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (rx_clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    pe_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = parity_of(32'(shift_q), 1'(PARITY_ODD)) != rx_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at the stop midpoint lets a back-to-back start edge resync.
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            if (perr_q) begin
              pe_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            state_d = ST_BREAK;
            ferr_d  = 1'b1;
            pe_d    = perr_q;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      pe_q    <= pe_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = pe_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: default-configuration DUT plus an even-parity DUT.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       dv_a, fe_a, pe_a, busy_a;
  logic       dv_b, fe_b, pe_b, busy_b;

  always #5 clk = ~clk;

  receiver dut (
    .rx_clk(clk), .rst_n(rst_n), .rx_in(rx_a), .data_out(data_a),
    .data_valid(dv_a), .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
  );

  receiver #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .rx_clk(clk), .rst_n(rst_n), .rx_in(rx_b), .data_out(data_b),
    .data_valid(dv_b), .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and timestamps, index 0 = dut, 1 = dut_p.
  int         dv_n[2] = '{0, 0};
  int         fe_n[2] = '{0, 0};
  int         pe_n[2] = '{0, 0};
  int         dv_last[2] = '{0, 0};
  int         rise_cyc[2] = '{0, 0};
  int         fall_cyc[2] = '{0, 0};
  logic       busy_prev[2] = '{1'b0, 1'b0};
  logic [7:0] dv_log[64];
  int         dv_log_cyc[64];

  always @(negedge clk) begin
    if (dv_a) begin
      if (dv_n[0] < 64) begin
        dv_log[dv_n[0]]     <= data_a;
        dv_log_cyc[dv_n[0]] <= cyc;
      end
      dv_n[0]    <= dv_n[0] + 1;
      dv_last[0] <= cyc;
    end
    if (dv_b) begin
      dv_n[1]    <= dv_n[1] + 1;
      dv_last[1] <= cyc;
    end
    if (fe_a) fe_n[0] <= fe_n[0] + 1;
    if (fe_b) fe_n[1] <= fe_n[1] + 1;
    if (pe_a) pe_n[0] <= pe_n[0] + 1;
    if (pe_b) pe_n[1] <= pe_n[1] + 1;
    if (busy_a && !busy_prev[0]) rise_cyc[0] <= cyc;
    if (!busy_a && busy_prev[0]) fall_cyc[0] <= cyc;
    if (busy_b && !busy_prev[1]) rise_cyc[1] <= cyc;
    if (!busy_b && busy_prev[1]) fall_cyc[1] <= cyc;
    busy_prev[0] <= busy_a;
    busy_prev[1] <= busy_b;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  // Called 1 time unit after a rising edge; each bit is held 16 cycles.
  task automatic send_frame(input bit which, input logic [7:0] d, input bit pen,
                            input bit pbit, input bit stop, output int start_c);
    start_c = cyc;
    drive(which, 1'b0);
    tick(16);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      tick(16);
    end
    if (pen) begin
      drive(which, pbit);
      tick(16);
    end
    drive(which, stop);
    tick(16);
  endtask

  typedef struct {
    bit         use_p;
    logic [7:0] d;
    bit         pbit;
    bit         stop;
    bit         exp_dv;
    bit         exp_fe;
    bit         exp_pe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s, s0, s1, s2, n0, f0, p0, lat;
    logic [7:0] prev;

    vecs[0] = '{0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5};
    vecs[1] = '{0, 8'h3C, 0, 0, 0, 1, 0, 8'hA5};
    vecs[2] = '{0, 8'h81, 0, 1, 1, 0, 0, 8'h81};
    vecs[3] = '{0, 8'h00, 0, 1, 1, 0, 0, 8'h00};
    vecs[4] = '{1, 8'h07, 1, 1, 1, 0, 0, 8'h07};
    vecs[5] = '{1, 8'h07, 0, 1, 0, 0, 1, 8'h07};
    vecs[6] = '{1, 8'h07, 0, 0, 0, 1, 1, 8'h07};

    rx_a = 1'b1;
    rx_b = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk("reset data_out", {24'd0, data_a}, 32'd0);
    chk("reset data_valid", {31'd0, dv_a}, 32'd0);
    chk("reset frame_err", {31'd0, fe_a}, 32'd0);
    chk("reset parity_err", {31'd0, pe_a}, 32'd0);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset busy_p", {31'd0, busy_b}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    for (int v = 0; v < 7; v++) begin
      int w;
      w  = vecs[v].use_p ? 1 : 0;
      n0 = dv_n[w];
      f0 = fe_n[w];
      p0 = pe_n[w];
      send_frame(vecs[v].use_p, vecs[v].d, vecs[v].use_p, vecs[v].pbit, vecs[v].stop, s);
      if (!vecs[v].stop) begin
        tick(40);
        drive(vecs[v].use_p, 1'b1);
      end
      tick(30);
      chk($sformatf("vec%0d valid count", v), dv_n[w] - n0, {31'd0, vecs[v].exp_dv});
      chk($sformatf("vec%0d frame_err count", v), fe_n[w] - f0, {31'd0, vecs[v].exp_fe});
      chk($sformatf("vec%0d parity_err count", v), pe_n[w] - p0, {31'd0, vecs[v].exp_pe});
      chk($sformatf("vec%0d data_out", v), {24'd0, w ? data_b : data_a}, {24'd0, vecs[v].exp_out});
      chk($sformatf("vec%0d start latency", v), rise_cyc[w] - s, 32'd3);
      if (vecs[v].exp_dv) begin
        lat = vecs[v].use_p ? 171 : 155;
        chk($sformatf("vec%0d valid cycle", v), dv_last[w] - s, lat);
        chk($sformatf("vec%0d busy fall", v), fall_cyc[w] - s, lat);
      end
    end

    // Glitch: four low cycles must be rejected at the start-bit midpoint.
    n0 = dv_n[0];
    f0 = fe_n[0];
    prev = data_a;
    s = cyc;
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    tick(40);
    chk("glitch busy rise", rise_cyc[0] - s, 32'd3);
    chk("glitch busy fall", fall_cyc[0] - s, 32'd11);
    chk("glitch no valid", dv_n[0] - n0, 32'd0);
    chk("glitch no frame_err", fe_n[0] - f0, 32'd0);
    chk("glitch data_out", {24'd0, data_a}, {24'd0, prev});

    // Back-to-back frames with no idle time between them.
    n0 = dv_n[0];
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, s0);
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, s1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, s2);
    tick(30);
    chk("b2b valid count", dv_n[0] - n0, 32'd3);
    chk("b2b word0", {24'd0, dv_log[n0]}, 32'h55);
    chk("b2b word1", {24'd0, dv_log[n0+1]}, 32'h00);
    chk("b2b word2", {24'd0, dv_log[n0+2]}, 32'hFF);
    chk("b2b first cycle", dv_log_cyc[n0] - s0, 32'd155);
    chk("b2b spacing 0-1", dv_log_cyc[n0+1] - dv_log_cyc[n0], 32'd160);
    chk("b2b spacing 1-2", dv_log_cyc[n0+2] - dv_log_cyc[n0+1], 32'd160);

    // Reset during data bit 4 discards the frame.
    n0 = dv_n[0];
    f0 = fe_n[0];
    p0 = pe_n[0];
    prev = 8'h12;
    rx_a = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx_a = prev[i];
      tick(16);
    end
    rx_a = prev[4];
    tick(8);
    chk("pre-reset busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset data_out", {24'd0, data_a}, 32'd0);
    chk("async reset busy", {31'd0, busy_a}, 32'd0);
    tick(3);
    chk("mid reset valid", {31'd0, dv_a}, 32'd0);
    chk("mid reset frame_err", {31'd0, fe_a}, 32'd0);
    chk("mid reset parity_err", {31'd0, pe_a}, 32'd0);
    rx_a = 1'b1;
    rst_n = 1'b1;
    tick(200);
    chk("post reset busy", {31'd0, busy_a}, 32'd0);
    chk("post reset no valid", dv_n[0] - n0, 32'd0);
    chk("post reset no frame_err", fe_n[0] - f0, 32'd0);
    chk("post reset no parity_err", pe_n[0] - p0, 32'd0);
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, s);
    tick(30);
    chk("after reset valid count", dv_n[0] - n0, 32'd1);
    chk("after reset data_out", {24'd0, data_a}, 32'h12);
    chk("after reset valid cycle", dv_last[0] - s, 32'd155);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
